controle_jogo_param: RTL and testbench
======================================

Name: controle_jogo_param

Overview:
- Parametrised control unit for the memory-sequence game: it runs the rounds, checks the player's moves and declares win, error or timeout.
- Unlike the previous generation, it owns its position, round and timer counters, and it plays back the sequence (show phase) before each round's input phase.
- It sits between the datapath (sequence memory, play register, comparator) and the board LEDs/displays.

Parameters:
- N_ROUNDS, 16, number of rounds in full mode; >=2 and even; ADDR_W must satisfy 2^ADDR_W >= N_ROUNDS.
- ADDR_W, 4, width of position/round counters and memory address.
- SHOW_CYCLES, 1000, cycles the LED is lit per shown position (>=1).
- GAP_CYCLES, 500, dark cycles after each shown position (>=1).
- TIMEOUT_CYCLES, 5000, cycles allowed in the wait state before timeout (>=2).
- MAX_LIVES, 3, attempts per game; used only with RETRY_EN; >=1.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high; state goes to INICIAL.
- iniciar  in  1  start/restart request, level-sampled.
- jogada  in  1  one-cycle pulse, move available.
- igual  in  1  comparator result: played value equals memory[endereco].
- modo  in  1  0 = N_ROUNDS rounds, 1 = N_ROUNDS/2 rounds; sampled in INICIALIZA.
- endereco  out  ADDR_W  current position (memory address).
- rodada  out  ADDR_W  current round index, 0-based.
- mostra_led  out  1  high while the memory value must be shown.
- zeraR  out  1  clear play register.
- registraR  out  1  load play register.
- acertou  out  1  game won.
- errou  out  1  game lost (wrong move or timeout).
- errou_timeout  out  1  game lost by timeout.
- pronto  out  1  game finished (any final state).
- vidas  out  3  remaining lives.
- db_estado  out  5  state code, debug only.

Behaviour:
- Moore FSM with registered state and counters pos, rodada, timer, limite and vidas; all outputs decode state or counters.
- Async reset:
  - state INICIAL; pos, rodada and timer = 0.
  - All outputs 0 except zeraR = 1.
  - Reset mid-game aborts immediately.
- db_estado codes:
  - INICIAL 0, INICIALIZA 1, INICIA_RODADA 2, MOSTRA 3, INTERVALO 4.
  - ESPERA 5, REGISTRA 6, COMPARA 7, PROXIMA 8, FIM_RODADA 9.
  - PROX_RODADA 10, RETENTA 11, FINAL_ACERTO 16, FINAL_ERRO 17, FINAL_TIMEOUT 18.
- INICIAL: zeraR = 1; iniciar -> INICIALIZA.
- INICIALIZA: pos = rodada = timer = 0; limite = modo ? N_ROUNDS/2 : N_ROUNDS; vidas = MAX_LIVES; go to INICIA_RODADA.
- INICIA_RODADA: pos = 0, timer = 0; go to MOSTRA.
- MOSTRA: mostra_led = 1; timer increments; at timer == SHOW_CYCLES-1, clear timer and go to INTERVALO.
- INTERVALO: timer increments; at timer == GAP_CYCLES-1, clear timer, then:
  - pos == rodada: pos = 0, go to ESPERA.
  - otherwise: pos++, go to MOSTRA.
- ESPERA:
  - timer increments.
  - jogada -> REGISTRA; jogada wins over a simultaneous timeout.
  - Otherwise, timer == TIMEOUT_CYCLES-1 -> FINAL_TIMEOUT.
- REGISTRA: registraR = 1; go to COMPARA.
- COMPARA:
  - !igual -> FINAL_ERRO.
  - igual and pos == rodada -> FIM_RODADA.
  - Otherwise -> PROXIMA.
- PROXIMA: pos++, timer = 0; go to ESPERA.
- FIM_RODADA: rodada == limite-1 -> FINAL_ACERTO, else PROX_RODADA.
- PROX_RODADA: rodada++; go to INICIA_RODADA.
- Final states:
  - pronto = 1 in all three.
  - acertou = 1 in FINAL_ACERTO.
  - errou = 1 in FINAL_ERRO and FINAL_TIMEOUT.
  - errou_timeout = 1 in FINAL_TIMEOUT.
  - iniciar -> INICIALIZA; otherwise stay.
- Ignored inputs: jogada outside ESPERA; iniciar outside INICIAL and the final states.
- Latency:
  - iniciar sampled -> mostra_led high after 3 edges.
  - Show phase of round k lasts (k+1)*(SHOW_CYCLES+GAP_CYCLES) cycles.
- Timer width: $clog2 of the largest cycle parameter. Counters never wrap, because limite <= 2^ADDR_W.

Optional Feature:
- Macro JOGO_RETRY_EN.
- Defined:
  - FINAL_ERRO/FINAL_TIMEOUT transitions taken with vidas > 1 go to RETENTA instead.
  - RETENTA: vidas--, go to INICIA_RODADA, replaying the same rodada.
  - With vidas == 1 the game ends as normal.
- Undefined: RETENTA is unreachable and vidas is held at 0.

Decomposition:
- Package jogo_pkg: state encodings and db_estado codes as localparams; helper function for the timer width.
- One natural sub-module: temporizador_jogo.
  - Ports: clear, enable, limit select.
  - Output: done when the count reaches the selected limit minus 1.
  - Used for the SHOW, GAP and TIMEOUT counts.

Test Plan (N_ROUNDS=4, ADDR_W=2, SHOW=3, GAP=2, TIMEOUT=5):
- Full win, modo=0, correct jogada each time -> 4 rounds with 1, 2, 3, 4 shown positions; acertou = pronto = 1, db_estado = 16, rodada = 3.
- Wrong move: igual = 0 at round 1 pos 0 -> FINAL_ERRO; errou = pronto = 1, errou_timeout = 0.
- Timeout: no jogada for 5 cycles in ESPERA -> FINAL_TIMEOUT, errou_timeout = 1. Simultaneous jogada on cycle 5 -> REGISTRA instead.
- Half mode: modo=1, all correct -> acertou after round index 1. Toggling modo mid-game has no effect.
- Reset asserted during MOSTRA -> state, outputs and counters return to reset values at once; iniciar then restarts normally.
- With JOGO_RETRY_EN and MAX_LIVES=2: first error -> RETENTA, vidas = 1, same round replays; second error -> FINAL_ERRO.

Source files
------------

// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jogo_pkg
// Description : State encodings (equal to the debug codes), timer-select codes
//               and the timer-width helper for controle_jogo_param.
// Revision    : 1.0 - initial release
// ============================================================================
package jogo_pkg;

    typedef enum logic [4:0] {
        ST_INICIAL       = 5'd0,
        ST_INICIALIZA    = 5'd1,
        ST_INICIA_RODADA = 5'd2,
        ST_MOSTRA        = 5'd3,
        ST_INTERVALO     = 5'd4,
        ST_ESPERA        = 5'd5,
        ST_REGISTRA      = 5'd6,
        ST_COMPARA       = 5'd7,
        ST_PROXIMA       = 5'd8,
        ST_FIM_RODADA    = 5'd9,
        ST_PROX_RODADA   = 5'd10,
        ST_RETENTA       = 5'd11,
        ST_FINAL_ACERTO  = 5'd16,
        ST_FINAL_ERRO    = 5'd17,
        ST_FINAL_TIMEOUT = 5'd18
    } estado_t;

    localparam logic [1:0] C_SEL_SHOW    = 2'd0;
    localparam logic [1:0] C_SEL_GAP     = 2'd1;
    localparam logic [1:0] C_SEL_TIMEOUT = 2'd2;

    // Never returns 0, so a single-cycle parameter set still yields a legal vector.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/temporizador_jogo.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_jogo
// Description : Shared cycle counter; done flags the last cycle of the
//               selected interval (SHOW, GAP or TIMEOUT).
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_jogo
    import jogo_pkg::*;
#(
    parameter int SHOW_CYCLES    = 1000,
    parameter int GAP_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TW             = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [1:0] sel,
    output logic       done
);

    localparam logic [TW-1:0] C_SHOW_LAST    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] C_GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] C_TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_count;
    logic [TW-1:0] w_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (enable)
            r_count <= r_count + TW'(1);
    end

    always_comb begin
        w_last = C_SHOW_LAST;
        case (sel)
            C_SEL_GAP:     w_last = C_GAP_LAST;
            C_SEL_TIMEOUT: w_last = C_TIMEOUT_LAST;
            default:       w_last = C_SHOW_LAST;
        endcase
    end

    assign done = (r_count == w_last);

endmodule
`default_nettype wire

// File: rtl/controle_jogo_param.sv
`default_nettype none
// ============================================================================
// Module      : controle_jogo_param
// Description : Memory-sequence game controller: show phase, input phase,
//               win/error/timeout. Optional retry lives via JOGO_RETRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_jogo_param
    import jogo_pkg::*;
#(
    parameter int N_ROUNDS       = 16,
    parameter int ADDR_W         = 4,
    parameter int SHOW_CYCLES    = 1000,
    parameter int GAP_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int MAX_LIVES      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic              igual,
    input  logic              modo,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] rodada,
    output logic              mostra_led,
    output logic              zeraR,
    output logic              registraR,
    output logic              acertou,
    output logic              errou,
    output logic              errou_timeout,
    output logic              pronto,
    output logic [2:0]        vidas,
    output logic [4:0]        db_estado
);

    localparam int TW = timer_width(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    // One extra bit: limite may equal 2^ADDR_W.
    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0]     C_LIM_FULL = LW'(N_ROUNDS);
    localparam logic [LW-1:0]     C_LIM_HALF = LW'(N_ROUNDS / 2);
    localparam logic [ADDR_W-1:0] C_ONE      = ADDR_W'(1);

    estado_t           r_state;
    estado_t           w_next;
    estado_t           w_alvo_erro;
    estado_t           w_alvo_timeout;
    logic [ADDR_W-1:0] r_pos;
    logic [ADDR_W-1:0] r_rodada;
    logic [LW-1:0]     r_limite;
    logic              w_tclear;
    logic              w_tenable;
    logic [1:0]        w_tsel;
    logic              w_tdone;
    logic              w_pos_fim;
    logic              w_ultima;

    assign w_pos_fim = (r_pos == r_rodada);
    assign w_ultima  = ({1'b0, r_rodada} == (r_limite - LW'(1)));

`ifdef JOGO_RETRY_EN
    logic [2:0] r_vidas;

    assign w_alvo_erro    = (r_vidas > 3'd1) ? ST_RETENTA : ST_FINAL_ERRO;
    assign w_alvo_timeout = (r_vidas > 3'd1) ? ST_RETENTA : ST_FINAL_TIMEOUT;
    assign vidas          = r_vidas;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_vidas <= 3'd0;
        else if (r_state == ST_INICIALIZA)
            r_vidas <= 3'(MAX_LIVES);
        else if (r_state == ST_RETENTA)
            r_vidas <= r_vidas - 3'd1;
    end
`else
    assign w_alvo_erro    = ST_FINAL_ERRO;
    assign w_alvo_timeout = ST_FINAL_TIMEOUT;
    assign vidas          = 3'd0;
`endif

    temporizador_jogo #(
        .SHOW_CYCLES    (SHOW_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (TW)
    ) u_temporizador (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_tclear),
        .enable (w_tenable),
        .sel    (w_tsel),
        .done   (w_tdone)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= ST_INICIAL;
        else
            r_state <= w_next;
    end

    // Timer is held clear outside the three timed states.
    always_comb begin
        w_next    = r_state;
        w_tclear  = 1'b1;
        w_tenable = 1'b0;
        w_tsel    = C_SEL_SHOW;
        case (r_state)
            ST_INICIAL:       if (iniciar) w_next = ST_INICIALIZA;
            ST_INICIALIZA:    w_next = ST_INICIA_RODADA;
            ST_INICIA_RODADA: w_next = ST_MOSTRA;
            ST_MOSTRA: begin
                w_tenable = 1'b1;
                w_tsel    = C_SEL_SHOW;
                w_tclear  = w_tdone;
                if (w_tdone) w_next = ST_INTERVALO;
            end
            ST_INTERVALO: begin
                w_tenable = 1'b1;
                w_tsel    = C_SEL_GAP;
                w_tclear  = w_tdone;
                if (w_tdone) w_next = w_pos_fim ? ST_ESPERA : ST_MOSTRA;
            end
            ST_ESPERA: begin
                w_tenable = 1'b1;
                w_tsel    = C_SEL_TIMEOUT;
                w_tclear  = jogada | w_tdone;
                if (jogada)       w_next = ST_REGISTRA;
                else if (w_tdone) w_next = w_alvo_timeout;
            end
            ST_REGISTRA:      w_next = ST_COMPARA;
            ST_COMPARA: begin
                if (!igual)         w_next = w_alvo_erro;
                else if (w_pos_fim) w_next = ST_FIM_RODADA;
                else                w_next = ST_PROXIMA;
            end
            ST_PROXIMA:       w_next = ST_ESPERA;
            ST_FIM_RODADA:    w_next = w_ultima ? ST_FINAL_ACERTO : ST_PROX_RODADA;
            ST_PROX_RODADA:   w_next = ST_INICIA_RODADA;
            ST_RETENTA:       w_next = ST_INICIA_RODADA;
            ST_FINAL_ACERTO, ST_FINAL_ERRO, ST_FINAL_TIMEOUT:
                if (iniciar) w_next = ST_INICIALIZA;
            default:          w_next = ST_INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pos    <= '0;
            r_rodada <= '0;
            r_limite <= '0;
        end else begin
            case (r_state)
                ST_INICIALIZA: begin
                    r_pos    <= '0;
                    r_rodada <= '0;
                    r_limite <= modo ? C_LIM_HALF : C_LIM_FULL;
                end
                ST_INICIA_RODADA: r_pos <= '0;
                ST_INTERVALO:
                    if (w_tdone) r_pos <= w_pos_fim ? '0 : r_pos + C_ONE;
                ST_PROXIMA:       r_pos <= r_pos + C_ONE;
                ST_PROX_RODADA:   r_rodada <= r_rodada + C_ONE;
                default: ;
            endcase
        end
    end

    assign endereco      = r_pos;
    assign rodada        = r_rodada;
    assign db_estado     = r_state;
    assign mostra_led    = (r_state == ST_MOSTRA);
    assign zeraR         = (r_state == ST_INICIAL);
    assign registraR     = (r_state == ST_REGISTRA);
    assign acertou       = (r_state == ST_FINAL_ACERTO);
    assign errou         = (r_state == ST_FINAL_ERRO) || (r_state == ST_FINAL_TIMEOUT);
    assign errou_timeout = (r_state == ST_FINAL_TIMEOUT);
    assign pronto        = acertou || errou;

endmodule
`default_nettype wire

// File: tb/tb_controle_jogo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_jogo_param
// Description : Directed bench: win, wrong move, timeout, half mode, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_jogo_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b1;
    logic       modo = 1'b0;
    logic [1:0] endereco;
    logic [1:0] rodada;
    logic       mostra_led, zeraR, registraR, acertou, errou, errou_timeout, pronto;
    logic [2:0] vidas;
    logic [4:0] db_estado;

    int checks = 0;
    int errors = 0;

`ifdef JOGO_RETRY_EN
    localparam int C_VIDAS_INI = 2;
`else
    localparam int C_VIDAS_INI = 0;
`endif

    controle_jogo_param #(
        .N_ROUNDS       (4),
        .ADDR_W         (2),
        .SHOW_CYCLES    (3),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (5),
        .MAX_LIVES      (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .jogada        (jogada),
        .igual         (igual),
        .modo          (modo),
        .endereco      (endereco),
        .rodada        (rodada),
        .mostra_led    (mostra_led),
        .zeraR         (zeraR),
        .registraR     (registraR),
        .acertou       (acertou),
        .errou         (errou),
        .errou_timeout (errou_timeout),
        .pronto        (pronto),
        .vidas         (vidas),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_game(input logic m);
        iniciar = 1'b1;
        modo    = m;
        tick();
        chk("inicializa", db_estado, 1);
        iniciar = 1'b0;
        tick();
        chk("inicia_rodada", db_estado, 2);
        chk("rodada_ini", rodada, 0);
        chk("vidas_ini", vidas, C_VIDAS_INI);
    endtask

    // Starts in INICIA_RODADA, ends in ESPERA.
    task automatic show_phase(input int k);
        for (int p = 0; p <= k; p++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("mostra_st", db_estado, 3);
                chk("mostra_led", mostra_led, 1);
                chk("mostra_end", endereco, p);
            end
            for (int c = 0; c < 2; c++) begin
                tick();
                chk("intervalo_st", db_estado, 4);
                chk("intervalo_led", mostra_led, 0);
            end
        end
        tick();
        chk("espera_st", db_estado, 5);
        chk("espera_end", endereco, 0);
    endtask

    // Full round with correct moves; ends in INICIA_RODADA or FINAL_ACERTO.
    task automatic run_round(input int k, input bit last);
        show_phase(k);
        for (int p = 0; p <= k; p++) begin
            jogada = 1'b1;
            igual  = 1'b1;
            tick();
            chk("registra_st", db_estado, 6);
            chk("registraR", registraR, 1);
            jogada = 1'b0;
            tick();
            chk("compara_st", db_estado, 7);
            tick();
            if (p < k) begin
                chk("proxima_st", db_estado, 8);
                tick();
                chk("espera2_st", db_estado, 5);
                chk("espera2_end", endereco, p + 1);
            end else begin
                chk("fim_rodada_st", db_estado, 9);
            end
        end
        tick();
        if (last) begin
            chk("final_acerto_st", db_estado, 16);
        end else begin
            chk("prox_rodada_st", db_estado, 10);
            tick();
            chk("nova_rodada_st", db_estado, 2);
            chk("nova_rodada", rodada, k + 1);
        end
    endtask

    task automatic wrong_move_round1(input int exp_state);
        show_phase(1);
        jogada = 1'b1;
        igual  = 1'b0;
        tick();
        jogada = 1'b0;
        tick();
        chk("compara_err_st", db_estado, 7);
        tick();
        chk("erro_dest_st", db_estado, exp_state);
        igual = 1'b1;
    endtask

    task automatic timeout_round1(input int exp_state);
        show_phase(1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("espera_hold_st", db_estado, 5);
        end
        tick();
        chk("timeout_dest_st", db_estado, exp_state);
    endtask

    initial begin
        #3;
        chk("rst_estado", db_estado, 0);
        chk("rst_zeraR", zeraR, 1);
        chk("rst_outs", {mostra_led, registraR, acertou, errou, errou_timeout, pronto}, 0);
        chk("rst_cnt", {endereco, rodada, vidas}, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("idle_st", db_estado, 0);

        // Full win, modo = 0
        start_game(1'b0);
        run_round(0, 1'b0);
        run_round(1, 1'b0);
        run_round(2, 1'b0);
        run_round(3, 1'b1);
        chk("win_flags", {acertou, pronto, errou, errou_timeout}, 4'b1100);
        chk("win_rodada", rodada, 3);
        tick();
        chk("win_hold_st", db_estado, 16);

        // Wrong move at round 1, position 0
        start_game(1'b0);
        run_round(0, 1'b0);
`ifdef JOGO_RETRY_EN
        wrong_move_round1(11);
        tick();
        chk("retenta_next_st", db_estado, 2);
        chk("retenta_vidas", vidas, 1);
        chk("retenta_rodada", rodada, 1);
`endif
        wrong_move_round1(17);
        chk("erro_flags", {errou, pronto, errou_timeout, acertou}, 4'b1100);

        // Timeout, preceded by a jogada coinciding with the timeout cycle
        start_game(1'b0);
        show_phase(0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("espera_sim_st", db_estado, 5);
        end
        jogada = 1'b1;
        tick();
        chk("sim_jogada_st", db_estado, 6);
        jogada = 1'b0;
        tick();
        tick();
        chk("sim_fim_st", db_estado, 9);
        tick();
        tick();
        chk("sim_round1_st", db_estado, 2);
`ifdef JOGO_RETRY_EN
        timeout_round1(11);
        tick();
        chk("retenta_to_vidas", vidas, 1);
`endif
        timeout_round1(18);
        chk("timeout_flags", {errou_timeout, errou, pronto, acertou}, 4'b1110);

        // Half mode, modo toggled mid-game
        start_game(1'b1);
        modo = 1'b0;
        run_round(0, 1'b0);
        run_round(1, 1'b1);
        chk("half_rodada", rodada, 1);
        chk("half_acertou", acertou, 1);

        // Reset during MOSTRA of round 1
        start_game(1'b0);
        run_round(0, 1'b0);
        tick();
        chk("pre_rst_st", db_estado, 3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_st", db_estado, 0);
        chk("async_rst_zeraR", zeraR, 1);
        chk("async_rst_led", mostra_led, 0);
        chk("async_rst_cnt", {endereco, rodada, vidas}, 0);
        tick();
        reset = 1'b0;
        start_game(1'b0);
        tick();
        chk("restart_led", mostra_led, 1);
        chk("restart_st", db_estado, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
